// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hold controller: FSM states, NOP word, control bundles.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMemWait = 2'd1,
    StTimeout = 2'd2
  } hold_state_e;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stall_ctrl_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } flush_ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles; terminal flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CntW        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            incr_i,
  output logic [CntW-1:0] count_o,
  output logic            terminal_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == CntW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_hold_controller.sv
// Stall/flush arbitration for a 5-stage pipeline with data-memory wait timeout.
// Optional build macro STALL_CYCLE_COUNTER_EN enables the stall cycle counter.
module pipeline_hold_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_mem_request,
  input  logic        dmem_ready,
  input  logic        ID_load_use_hazard,
  input  logic        EX_redirect,
  input  logic        WB_trap_flush,
  output logic        pc_stall,
  output logic        IF_ID_stall,
  output logic        ID_EX_stall,
  output logic        EX_MEM_stall,
  output logic        MEM_WB_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        EX_MEM_flush,
  output logic        MEM_WB_flush,
  output logic        bus_error,
  output logic [31:0] stall_cycle_count
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  hold_state_e     state_q, state_d;
  logic [CntW-1:0] wait_cnt;
  logic            wait_tc;
  logic            cnt_clear;
  logic            cnt_incr;
  logic            mem_hold;
  stall_ctrl_t     stall;
  flush_ctrl_t     flush;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CntW       (CntW)
  ) u_mem_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .incr_i    (cnt_incr),
    .count_o   (wait_cnt),
    .terminal_o(wait_tc)
  );

  always_comb begin
    mem_hold  = MEM_mem_request & ~dmem_ready &
                ((state_q == StIdle) | (state_q == StMemWait));
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;

    if (WB_trap_flush) begin
      state_d   = StIdle;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_hold) begin
            state_d  = StMemWait;
            cnt_incr = 1'b1;
          end
        end
        StMemWait: begin
          if (!mem_hold) begin
            state_d   = StIdle;
            cnt_clear = 1'b1;
          end else if (wait_tc) begin
            state_d = StTimeout;
          end else begin
            cnt_incr = 1'b1;
          end
        end
        StTimeout: begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end
        default: begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // Redirect is deliberately ignored under mem_hold: EX is frozen and replays it on release.
  always_comb begin
    stall = '0;
    flush = '0;
    if (reset) begin
      stall = '0;
    end else if (WB_trap_flush || (state_q == StTimeout)) begin
      flush = '1;
    end else if (mem_hold) begin
      stall.pc     = 1'b1;
      stall.if_id  = 1'b1;
      stall.id_ex  = 1'b1;
      stall.ex_mem = 1'b1;
      flush.mem_wb = 1'b1;
    end else if (EX_redirect) begin
      flush.if_id = 1'b1;
      flush.id_ex = 1'b1;
    end else if (ID_load_use_hazard) begin
      stall.pc    = 1'b1;
      stall.if_id = 1'b1;
      flush.id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_stall     = stall.pc;
  assign IF_ID_stall  = stall.if_id;
  assign ID_EX_stall  = stall.id_ex;
  assign EX_MEM_stall = stall.ex_mem;
  assign MEM_WB_stall = stall.mem_wb;
  assign IF_ID_flush  = flush.if_id;
  assign ID_EX_flush  = flush.id_ex;
  assign EX_MEM_flush = flush.ex_mem;
  assign MEM_WB_flush = flush.mem_wb;
  assign bus_error    = (state_q == StTimeout) & ~WB_trap_flush & ~reset;

`ifdef STALL_CYCLE_COUNTER_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (pc_stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycle_count = stall_cnt_q;
`else
  assign stall_cycle_count = '0;
`endif

endmodule

// File: doc/pipeline_hold_controller.md
PIPELINE_HOLD_CONTROLLER -- requirements
Module: pipeline_hold_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16 (range 2..255); maximum consecutive data-memory wait cycles before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port MEM_mem_request  input  1  load/store occupying the MEM stage this cycle.
REQ-005 SHALL have port dmem_ready  input  1  data memory completes the MEM-stage access this cycle.
REQ-006 SHALL have port ID_load_use_hazard  input  1  ID instruction depends on the load in EX.
REQ-007 SHALL have port EX_redirect  input  1  branch/jump taken in EX; the PC is redirected.
REQ-008 SHALL have port WB_trap_flush  input  1  trap/exception taken at WB.
REQ-009 SHALL have ports pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall  output  1 each  hold the PC or the named pipeline register.
REQ-010 SHALL have ports IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  output  1 each  load a NOP bubble into the named register.
REQ-011 SHALL have port bus_error  output  1  one-cycle pulse; memory access aborted on timeout.
REQ-012 SHALL have port stall_cycle_count  output  32  count of cycles with pc_stall high.

Function
REQ-013 SHALL define mem_hold = MEM_mem_request AND NOT dmem_ready, evaluated combinationally in states IDLE and MEM_WAIT.
REQ-014 SHALL implement FSM states IDLE, MEM_WAIT, TIMEOUT, plus wait counter wait_cnt of width clog2(MEM_TIMEOUT+1).
REQ-015 IDLE: mem_hold -> MEM_WAIT with wait_cnt=1; otherwise stay IDLE.
REQ-016 MEM_WAIT: NOT mem_hold -> IDLE with wait_cnt=0; mem_hold AND wait_cnt==MEM_TIMEOUT-1 -> TIMEOUT; otherwise wait_cnt+1.
REQ-017 TIMEOUT: lasts exactly one cycle; bus_error=1; all four flushes=1; all stalls=0; next state IDLE with wait_cnt=0.
REQ-018 Priority, highest first: WB_trap_flush, TIMEOUT, mem_hold, EX_redirect, ID_load_use_hazard.
REQ-019 WB_trap_flush: all four flushes=1, all stalls=0; next state IDLE with wait_cnt=0 from any state; no bus_error.
REQ-020 mem_hold: pc_stall, IF_ID_stall, ID_EX_stall, and EX_MEM_stall=1; MEM_WB_flush=1; MEM_WB_stall=0; all other flushes=0.
REQ-021 EX_redirect without mem_hold: IF_ID_flush=1 and ID_EX_flush=1; no stalls.
REQ-022 EX_redirect during mem_hold SHALL be ignored; it is held in EX by EX_MEM_stall and acted on once the hold releases.
REQ-023 ID_load_use_hazard alone: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1; others 0.
REQ-024 ID_load_use_hazard with EX_redirect: the redirect outcome only (the hazard instruction is squashed).
REQ-025 SHALL leave all stall/flush outputs at 0 when no condition is active.
REQ-026 Stall/flush outputs SHALL be combinational from the current state and inputs (zero latency); bus_error SHALL be decoded from the state register.
REQ-027 dmem_ready in the same cycle as the request SHALL produce no stall (single-cycle access).

Reset
REQ-028 While reset=1, all stall and flush outputs and bus_error SHALL be 0.
REQ-029 Reset SHALL set state=IDLE, wait_cnt=0, stall_cycle_count=0 at the edge; reset in MEM_WAIT SHALL abort the wait without bus_error.

Configuration
REQ-030 Macro STALL_CYCLE_COUNTER_EN defined: stall_cycle_count increments by 1 each non-reset cycle with pc_stall=1 and wraps 0xFFFFFFFF->0.
REQ-031 Macro STALL_CYCLE_COUNTER_EN undefined: the port remains and is tied to 0; no counter flops.

Structure
REQ-032 Package pipeline_ctrl_pkg SHALL hold the FSM state encoding (IDLE=2'd0, MEM_WAIT=2'd1, TIMEOUT=2'd2) and the NOP encoding constant 32'h0000_0013.
REQ-033 The wait counter and its terminal-count compare SHALL be sub-module mem_wait_timer (clear, increment, and terminal-count output).

Verification (MEM_TIMEOUT=4 unless stated)
REQ-034 Request with dmem_ready=1 same cycle -> no stall or flush, state stays IDLE.
REQ-035 Request with ready asserted on 3rd cycle -> cycles 0-1 show the four stalls plus MEM_WB_flush, cycle 2 all 0, state IDLE.
REQ-036 Request with ready never asserted -> 4 hold cycles, cycle 4 bus_error=1 with all flushes, cycle 5 IDLE; a second request restarts from wait_cnt=1.
REQ-037 EX_redirect in hold cycle 1, ready in cycle 2 -> flush suppressed in cycle 1, IF_ID_flush and ID_EX_flush in cycle 2.
REQ-038 WB_trap_flush in hold cycle 2 -> all flushes=1 that cycle, next IDLE, bus_error never asserted.
REQ-039 With STALL_CYCLE_COUNTER_EN: 3 load-use cycles then reset -> stall_cycle_count reads 3, then 0; preload near 0xFFFFFFFF and stall 2 cycles -> wraps to 0.
